// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the writeback trace buffer: default widths and
// the capture state encoding.
package wb_trace_buffer_pkg;

    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_DONE    = 2'd2
    } tr_state_e;

endpackage

// File: rtl/wb_trace_buffer_fifo_mem.sv
// Trace entry storage: synchronous write, registered read with write-to-read
// bypass so an entry written into the head slot is visible one edge later.
module wb_trace_buffer_fifo_mem #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures (reg, data, cycle stamp) events into a
// circular buffer drained through a valid/ready port, plus cycle/flush/stall counters.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int unsigned  DATA_W  = DATA_W_DEF,
    parameter int unsigned  REG_W   = REG_W_DEF,
    parameter int unsigned  DEPTH   = 16,
    parameter int unsigned  CNT_W   = 32,
    parameter bit           SKIP_R0 = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned LW      = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reg_write_i,
    input  logic [REG_W-1:0]  write_reg_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              flush_pulse_i,
    input  logic              pc_write_i,
    input  logic              arm_i,
    input  logic              stop_on_full_i,
    input  logic [LW-1:0]     post_count_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [REG_W-1:0]  rd_reg_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  rd_cycle_o,
    output logic [LW-1:0]     level_o,
    output logic              overflow_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [CNT_W-1:0]  flush_count_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam int unsigned EW = REG_W + DATA_W + CNT_W;

    tr_state_e        state_q, state_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]    level_q, level_d, cap_cnt_q, cap_cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, flush_q, flush_d, stall_q, stall_d;

    logic          ev, rd_valid, pop, full, capturing;
    logic          push, ovwr, drop, we, hit_post;
    logic [EW-1:0] rdata;

    assign ev        = reg_write_i && !(SKIP_R0 && (write_reg_i == '0));
    assign rd_valid  = (level_q != '0);
    assign pop       = rd_valid && rd_ready_i;
    assign full      = (level_q == LW'(DEPTH));
    assign capturing = (state_q == TR_CAPTURE);
    // A pop in the same cycle frees the head slot, so a full buffer still accepts the push.
    assign push      = capturing && ev && (!full || pop);
    assign ovwr      = capturing && ev && full && !pop && !stop_on_full_i;
    assign drop      = capturing && ev && full && !pop && stop_on_full_i;
    assign we        = push || ovwr;
    assign hit_post  = (post_count_i != '0) && ((cap_cnt_q + LW'(1)) == post_count_i);

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        cap_cnt_d = cap_cnt_q;

        if (we) begin
            tail_d    = tail_q + AW'(1);
            cap_cnt_d = cap_cnt_q + LW'(1);
        end
        if (pop || ovwr) begin
            head_d = head_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        if (ovwr || drop) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            TR_IDLE, TR_DONE: begin
                if (arm_i) begin
                    state_d   = TR_CAPTURE;
                    ovf_d     = 1'b0;
                    cap_cnt_d = '0;
                end
            end
            TR_CAPTURE: begin
                if (arm_i) begin
                    cap_cnt_d = '0;
                end else if (drop || (we && hit_post)) begin
                    state_d = TR_DONE;
                end
            end
            default: state_d = TR_IDLE;
        endcase
    end

    always_comb begin
        cycle_d = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
        flush_d = (flush_pulse_i && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
        stall_d = (!pc_write_i && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= TR_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            cap_cnt_q <= '0;
            cycle_q   <= '0;
            flush_q   <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            cap_cnt_q <= cap_cnt_d;
            cycle_q   <= cycle_d;
            flush_q   <= flush_d;
            stall_q   <= stall_d;
        end
    end

    // Reading at the next head pointer keeps the registered output aligned with head_q.
    wb_trace_buffer_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (we),
        .waddr_i (tail_q),
        .wdata_i ({write_reg_i, write_data_i, cycle_q}),
        .raddr_i (head_d),
        .rdata_o (rdata)
    );

    assign rd_valid_o    = rd_valid;
    assign rd_reg_o      = rd_valid ? rdata[EW-1 -: REG_W]    : '0;
    assign rd_data_o     = rd_valid ? rdata[CNT_W +: DATA_W]  : '0;
    assign rd_cycle_o    = rd_valid ? rdata[CNT_W-1:0]        : '0;
    assign level_o       = level_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = capturing;
    assign cycle_count_o = cycle_q;
    assign flush_count_o = flush_q;
    assign stall_count_o = stall_q;

endmodule
